// File: rtl/reg_scoreboard.sv
// Issue-side register hazard scoreboard: counts in-flight writers per register,
// stalls decode on pending sources or counter saturation, retires on writeback.
module reg_scoreboard #(
   parameter int NREG  = 32,
   parameter int CNT_W = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rs,
   input  logic [4:0]      issue_rt,
   input  logic            issue_use_rs,
   input  logic            issue_use_rt,
   input  logic            issue_wr,
   input  logic [4:0]      issue_rd,
   input  logic            wb_regwrite,
   input  logic [4:0]      wb_rd,
   output logic            issue_stall,
   output logic            issue_accept,
   output logic [NREG-1:0] busy_mask,
   output logic [31:0]     stall_cycles,
   output logic            wb_underflow
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   logic [CNT_W-1:0] cnt      [NREG];
   logic [CNT_W-1:0] cnt_next [NREG];
   logic [NREG-1:0]  inc_vec;
   logic [NREG-1:0]  dec_vec;
   logic [NREG-1:0]  busy_next;

   logic [CNT_W-1:0] cnt_rs;
   logic [CNT_W-1:0] cnt_rt;
   logic [CNT_W-1:0] cnt_rd;
   logic [CNT_W-1:0] cnt_wb;
   logic             rs_hazard;
   logic             rt_hazard;
   logic             rd_saturated;
   logic             underflow_now;

   assign cnt_rs = cnt[issue_rs];
   assign cnt_rt = cnt[issue_rt];
   assign cnt_rd = cnt[issue_rd];
   assign cnt_wb = cnt[wb_rd];

   // A source whose last pending writer retires this cycle is not a hazard:
   // the register file writes on the falling edge before the next read.
   always_comb begin
      rs_hazard    = 1'b0;
      rt_hazard    = 1'b0;
      rd_saturated = 1'b0;
      if (issue_use_rs && (issue_rs != 5'd0) && (cnt_rs != CNT_ZERO))
         rs_hazard = !(wb_regwrite && (wb_rd == issue_rs) && (cnt_rs == CNT_ONE));
      if (issue_use_rt && (issue_rt != 5'd0) && (cnt_rt != CNT_ZERO))
         rt_hazard = !(wb_regwrite && (wb_rd == issue_rt) && (cnt_rt == CNT_ONE));
      if (issue_wr && (issue_rd != 5'd0) && (cnt_rd == CNT_MAX))
         rd_saturated = !(wb_regwrite && (wb_rd == issue_rd));
   end

   assign issue_stall   = issue_valid && (rs_hazard || rt_hazard || rd_saturated);
   assign issue_accept  = issue_valid && !issue_stall;
   assign underflow_now = wb_regwrite && (wb_rd != 5'd0) && (cnt_wb == CNT_ZERO);

   // Per-register counter update; register 0 is never tracked.
   always_comb begin
      inc_vec   = '0;
      dec_vec   = '0;
      busy_next = '0;
      for (int i = 0; i < NREG; i++) begin
         cnt_next[i] = cnt[i];
         if (i != 0) begin
            inc_vec[i] = issue_accept && issue_wr && (issue_rd == 5'(i));
            dec_vec[i] = wb_regwrite && (wb_rd == 5'(i)) && (cnt[i] != CNT_ZERO);
            if (inc_vec[i] && !dec_vec[i])
               cnt_next[i] = cnt[i] + CNT_ONE;
            else if (dec_vec[i] && !inc_vec[i])
               cnt_next[i] = cnt[i] - CNT_ONE;
         end else begin
            cnt_next[i] = CNT_ZERO;
         end
         busy_next[i] = (cnt_next[i] != CNT_ZERO);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++)
            cnt[i] <= CNT_ZERO;
         busy_mask    <= '0;
         stall_cycles <= '0;
         wb_underflow <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++)
            cnt[i] <= cnt_next[i];
         busy_mask <= busy_next;
         if (issue_stall && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
         if (underflow_now)
            wb_underflow <= 1'b1;
      end
   end

endmodule
